// File: rtl/bist_controller.sv
// BIST sequencer: clears the MISR, runs the pattern generator for NUM_PATTERNS cycles,
// then latches the final signature and grades it against GOLDEN_SIG.
module bist_controller #(
   parameter int unsigned NUM_PATTERNS = 8,
   parameter logic [3:0]  GOLDEN_SIG   = 4'h6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] signature,
   output logic       test_mode,
   output logic       tpg_load,
   output logic       tpg_enable,
   output logic       ora_reset_n,
   output logic [7:0] pattern_count,
   output logic [3:0] sig_captured,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic       fail
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      COMPARE = 3'd3,
      DONE    = 3'd4
   } state_t;

   // Count value seen during the final RUN cycle; the exit edge brings it to NUM_PATTERNS.
   localparam logic [7:0] LAST_COUNT = 8'(NUM_PATTERNS - 1);

   state_t state;

   // NOTE: every register here, including the captured signature, gets an explicit async
   // reset value; non-blocking (<=) assignments keep all of them updating from pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         pattern_count <= 8'd0;
         sig_captured  <= 4'd0;
         pass          <= 1'b0;
         fail          <= 1'b0;
      end else if (abort) begin
         // Abort outranks start in every state; the last captured signature is kept.
         state         <= IDLE;
         pattern_count <= 8'd0;
         pass          <= 1'b0;
         fail          <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) state <= CLEAR;
            end
            CLEAR: begin
               pattern_count <= 8'd0;
               state         <= RUN;
            end
            RUN: begin
               pattern_count <= pattern_count + 8'd1;
               if (pattern_count == LAST_COUNT) state <= COMPARE;
            end
            COMPARE: begin
               sig_captured <= signature;
               pass         <= (signature == GOLDEN_SIG);
               fail         <= (signature != GOLDEN_SIG);
               state        <= DONE;
            end
            DONE: begin
               if (start) begin
                  pass  <= 1'b0;
                  fail  <= 1'b0;
                  state <= CLEAR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Moore decode straight from the state register.
   assign test_mode   = (state == CLEAR) || (state == RUN) || (state == COMPARE);
   assign tpg_load    = (state == CLEAR);
   assign tpg_enable  = (state == RUN);
   assign ora_reset_n = (state != CLEAR);
   assign busy        = (state == CLEAR) || (state == RUN) || (state == COMPARE);
   assign done        = (state == DONE);

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: a full-adder CUT, counting pattern generator and 4-bit MISR
// surround two controller instances (8 patterns and 1 pattern); results come from a timeline model.
module tb_bist_controller;

   localparam int N8 = 8;
   localparam int N1 = 1;
   // {test_mode, tpg_load, tpg_enable, ora_reset_n, busy, done, pass, fail, pattern_count, sig_captured}
   localparam logic [19:0] RESET_OUTS = {6'b000100, 2'b00, 8'd0, 4'd0};

   logic clock = 1'b0;
   logic reset, start, abort, start_1, abort_1, fault;
   logic test_mode, tpg_load, tpg_enable, ora_reset_n, busy, done, pass, fail;
   logic [7:0] pattern_count;
   logic [3:0] sig_captured, signature;
   logic test_mode_1, tpg_load_1, tpg_enable_1, ora_reset_n_1, busy_1, done_1, pass_1, fail_1;
   logic [7:0] pattern_count_1;
   logic [3:0] sig_captured_1, signature_1;
   logic [19:0] outs8, outs1;
   logic [5:0] moore8, moore1;

   int compared = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   bist_controller #(.NUM_PATTERNS(N8), .GOLDEN_SIG(4'h6)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort), .signature(signature),
      .test_mode(test_mode), .tpg_load(tpg_load), .tpg_enable(tpg_enable),
      .ora_reset_n(ora_reset_n), .pattern_count(pattern_count), .sig_captured(sig_captured),
      .busy(busy), .done(done), .pass(pass), .fail(fail));

   bist_controller #(.NUM_PATTERNS(N1), .GOLDEN_SIG(4'h0)) dut_1 (
      .clock(clock), .reset(reset), .start(start_1), .abort(abort_1), .signature(signature_1),
      .test_mode(test_mode_1), .tpg_load(tpg_load_1), .tpg_enable(tpg_enable_1),
      .ora_reset_n(ora_reset_n_1), .pattern_count(pattern_count_1), .sig_captured(sig_captured_1),
      .busy(busy_1), .done(done_1), .pass(pass_1), .fail(fail_1));

   assign moore8 = {test_mode, tpg_load, tpg_enable, ora_reset_n, busy, done};
   assign moore1 = {test_mode_1, tpg_load_1, tpg_enable_1, ora_reset_n_1, busy_1, done_1};
   assign outs8  = {moore8, pass, fail, pattern_count, sig_captured};
   assign outs1  = {moore1, pass_1, fail_1, pattern_count_1, sig_captured_1};

   // One MISR compression of the full-adder response to pattern {a,b,cin}; response injected at bits [2:1].
   function automatic logic [3:0] misr_step(input logic [3:0] m, input logic [2:0] p, input logic stuck);
      logic sum, carry;
      sum   = (^p) & ~stuck;
      carry = (p[2] & p[1]) | (p[2] & p[0]) | (p[1] & p[0]);
      return {m[2:0], m[3]} ^ {1'b0, carry, sum, 1'b0};
   endfunction

   // Signature after n compressions of patterns 0,1,2,... from a cleared MISR.
   function automatic logic [3:0] expected_sig(input int n, input logic stuck);
      logic [3:0] m;
      m = 4'd0;
      for (int i = 0; i < n; i++) m = misr_step(m, 3'(i), stuck);
      return m;
   endfunction

   // Expected {test_mode, tpg_load, tpg_enable, ora_reset_n, busy, done} k edges after the start edge.
   function automatic logic [5:0] moore_at(input int k, input int n);
      if (k == 1)          return 6'b110010;
      else if (k <= n + 1) return 6'b101110;
      else if (k == n + 2) return 6'b100110;
      else                 return 6'b000101;
   endfunction

   // Environment: pattern generator and MISR around each controller.
   logic [2:0] tpg8 = 3'd0, tpg1 = 3'd0;
   logic [3:0] misr8 = 4'd0, misr1 = 4'd0;
   always @(posedge clock)
      if (tpg_load) tpg8 <= 3'd0; else if (tpg_enable) tpg8 <= tpg8 + 3'd1;
   always @(posedge clock or negedge ora_reset_n)
      if (!ora_reset_n) misr8 <= 4'd0;
      else misr8 <= misr_step(misr8, test_mode ? tpg8 : 3'd0, fault);
   always @(posedge clock)
      if (tpg_load_1) tpg1 <= 3'd0; else if (tpg_enable_1) tpg1 <= tpg1 + 3'd1;
   always @(posedge clock or negedge ora_reset_n_1)
      if (!ora_reset_n_1) misr1 <= 4'd0;
      else misr1 <= misr_step(misr1, test_mode_1 ? tpg1 : 3'd0, fault);
   assign signature   = misr8;
   assign signature_1 = misr1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; abort = 1'b0; start_1 = 1'b0; abort_1 = 1'b0; fault = 1'b0;
      tick(); tick();
      compared++;
      if (outs8 !== RESET_OUTS) begin
         mismatched++; $display("FAIL reset_outs8: got %h want %h", outs8, RESET_OUTS);
      end
      compared++;
      if (outs1 !== RESET_OUTS) begin
         mismatched++; $display("FAIL reset_outs1: got %h want %h", outs1, RESET_OUTS);
      end
      #2 reset = 1'b1;
      tick(); tick();
      compared++;
      if (outs8 !== RESET_OUTS) begin
         mismatched++; $display("FAIL idle_after_reset: got %h want %h", outs8, RESET_OUTS);
      end
   endtask

   task automatic test_golden();
      int k;
      fault = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (k = 1; k <= 40; k++) begin
         if (k <= N8 + 3) begin
            compared++;
            if (moore8 !== moore_at(k, N8)) begin
               mismatched++; $display("FAIL golden_moore k=%0d: got %b want %b", k, moore8, moore_at(k, N8));
            end
         end
         if (k >= 2 && k <= N8 + 1) begin
            compared++;
            if (pattern_count !== 8'(k - 2)) begin
               mismatched++; $display("FAIL golden_count k=%0d: got %0d want %0d", k, pattern_count, k - 2);
            end
         end
         if (done === 1'b1) break;
         tick();
      end
      compared++;
      if (k != N8 + 3) begin
         mismatched++; $display("FAIL golden_latency: got %0d edges want %0d", k, N8 + 3);
      end
      compared++;
      if ({pass, fail, sig_captured, pattern_count} !== {2'b10, 4'h6, 8'(N8)}) begin
         mismatched++;
         $display("FAIL golden_result: got pass=%b fail=%b sig=%h count=%0d want pass=1 fail=0 sig=6 count=%0d",
                  pass, fail, sig_captured, pattern_count, N8);
      end
      compared++;
      if (sig_captured !== expected_sig(N8, 1'b0)) begin
         mismatched++; $display("FAIL golden_model_sig: got %h want %h", sig_captured, expected_sig(N8, 1'b0));
      end
      tick();
      compared++;
      if ({done, pass, fail, sig_captured} !== {3'b110, 4'h6}) begin
         mismatched++; $display("FAIL done_hold: got %b%b%b sig=%h want 110 sig=6", done, pass, fail, sig_captured);
      end
   endtask

   task automatic test_fault();
      fault = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      compared++;
      if ({pass, fail, tpg_load} !== 3'b001) begin
         mismatched++; $display("FAIL restart_clears: got pass=%b fail=%b load=%b want 0 0 1", pass, fail, tpg_load);
      end
      for (int b = 0; b < 40 && done !== 1'b1; b++) tick();
      compared++;
      if ({done, pass, fail} !== 3'b101) begin
         mismatched++; $display("FAIL fault_result: got done=%b pass=%b fail=%b want 1 0 1", done, pass, fail);
      end
      compared++;
      if (sig_captured !== expected_sig(N8, 1'b1)) begin
         mismatched++; $display("FAIL fault_sig: got %h want %h", sig_captured, expected_sig(N8, 1'b1));
      end
   endtask

   task automatic test_back_to_back();
      int clr_cycles, load_cycles, prev;
      fault = 1'b0; clr_cycles = 0; load_cycles = 0; prev = 0;
      start = 1'b1; tick();
      for (int k = 1; k <= N8 + 5; k++) begin
         if (k <= N8 + 3) begin
            if (ora_reset_n === 1'b0) clr_cycles++;
            if (tpg_load === 1'b1) load_cycles++;
         end
         if (k >= 2 && k <= N8 + 2) begin
            compared++;
            if (int'(pattern_count) < prev || int'(pattern_count) > N8 || busy !== 1'b1) begin
               mismatched++; $display("FAIL held_count k=%0d: got %0d busy=%b want >=%0d busy=1", k, pattern_count, busy, prev);
            end
            prev = int'(pattern_count);
         end
         if (k == N8 + 3) begin
            compared++;
            if ({done, pass} !== 2'b11) begin
               mismatched++; $display("FAIL held_done: got done=%b pass=%b want 1 1", done, pass);
            end
         end
         if (k == N8 + 4) begin
            compared++;
            if ({done, pass, fail, ora_reset_n} !== 4'b0000) begin
               mismatched++; $display("FAIL held_restart: got %b%b%b%b want 0000", done, pass, fail, ora_reset_n);
            end
         end
         if (k == N8 + 5) begin
            compared++;
            if ({ora_reset_n, tpg_enable} !== 2'b11) begin
               mismatched++; $display("FAIL clear_one_cycle: got orn=%b en=%b want 1 1", ora_reset_n, tpg_enable);
            end
         end
         if (k < N8 + 5) tick();
      end
      start = 1'b0;
      compared++;
      if (clr_cycles != 1 || load_cycles != 1 || prev != N8) begin
         mismatched++; $display("FAIL held_single_clear: got clr=%0d load=%0d last=%0d want 1 1 %0d", clr_cycles, load_cycles, prev, N8);
      end
      for (int b = 0; b < 40 && done !== 1'b1; b++) tick();
      compared++;
      if ({done, pass, sig_captured} !== {2'b11, 4'h6}) begin
         mismatched++; $display("FAIL held_second_run: got done=%b pass=%b sig=%h want 1 1 6", done, pass, sig_captured);
      end
   endtask

   task automatic test_abort();
      int b;
      start = 1'b1; tick(); start = 1'b0;
      for (b = 0; b < 40 && !(tpg_enable === 1'b1 && pattern_count === 8'd3); b++) tick();
      compared++;
      if (b >= 40) begin
         mismatched++; $display("FAIL abort_reach_count3: got timeout want RUN with count 3");
      end
      abort = 1'b1; tick(); abort = 1'b0;
      compared++;
      if ({moore8, pass, fail, pattern_count, sig_captured} !== {6'b000100, 2'b00, 8'd0, 4'h6}) begin
         mismatched++; $display("FAIL abort_idle: got %h want %h", outs8, {6'b000100, 2'b00, 8'd0, 4'h6});
      end
      tick(); tick(); tick();
      compared++;
      if ({busy, done, test_mode} !== 3'b000) begin
         mismatched++; $display("FAIL abort_stays_idle: got busy=%b done=%b tm=%b want 0 0 0", busy, done, test_mode);
      end
      // Abort at a random point of a run, sometimes with start asserted at the same edge.
      for (int it = 0; it < 4; it++) begin
         int k_ab;
         k_ab = int'($urandom_range(1, N8 + 3));
         start = 1'b1; tick(); start = 1'b0;
         for (int k = 1; k < k_ab; k++) tick();
         abort = 1'b1; start = 1'($urandom_range(0, 1)); tick(); abort = 1'b0; start = 1'b0;
         compared++;
         if ({moore8, pass, fail, pattern_count} !== {6'b000100, 2'b00, 8'd0}) begin
            mismatched++; $display("FAIL random_abort k=%0d: got %h want %h", k_ab, outs8[19:4], {6'b000100, 2'b00, 8'd0});
         end
      end
   endtask

   task automatic test_random_runs();
      for (int it = 0; it < 5; it++) begin
         logic [3:0] want_sig;
         fault = 1'($urandom_range(0, 1));
         want_sig = expected_sig(N8, fault);
         repeat ($urandom_range(0, 3)) tick();
         start = 1'b1; tick();
         repeat ($urandom_range(0, 2)) tick();
         start = 1'b0;
         for (int b = 0; b < 40 && done !== 1'b1; b++) tick();
         compared++;
         if ({done, pass, fail, sig_captured, pattern_count} !==
             {1'b1, want_sig == 4'h6, want_sig != 4'h6, want_sig, 8'(N8)}) begin
            mismatched++;
            $display("FAIL random_run fault=%b: got done=%b pass=%b fail=%b sig=%h count=%0d want sig=%h",
                     fault, done, pass, fail, sig_captured, pattern_count, want_sig);
         end
      end
      fault = 1'b0;
   endtask

   task automatic test_async_reset();
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      #($urandom_range(1, 3));
      reset = 1'b0;
      #1;
      compared++;
      if (outs8 !== RESET_OUTS) begin
         mismatched++; $display("FAIL async_reset: got %h want %h", outs8, RESET_OUTS);
      end
      tick();
      #2 reset = 1'b1;
      repeat (4) tick();
      compared++;
      if (outs8 !== RESET_OUTS) begin
         mismatched++; $display("FAIL no_activity_after_reset: got %h want %h", outs8, RESET_OUTS);
      end
   endtask

   task automatic test_single_pattern();
      int k, en_cycles;
      en_cycles = 0; fault = 1'b0;
      start_1 = 1'b1; tick(); start_1 = 1'b0;
      for (k = 1; k <= 20; k++) begin
         if (k <= N1 + 3) begin
            compared++;
            if (moore1 !== moore_at(k, N1)) begin
               mismatched++; $display("FAIL n1_moore k=%0d: got %b want %b", k, moore1, moore_at(k, N1));
            end
         end
         if (tpg_enable_1 === 1'b1) en_cycles++;
         if (done_1 === 1'b1) break;
         tick();
      end
      compared++;
      if (k != 4 || en_cycles != 1) begin
         mismatched++; $display("FAIL n1_latency: got edges=%0d en=%0d want 4 1", k, en_cycles);
      end
      compared++;
      if ({pass_1, fail_1, pattern_count_1, sig_captured_1} !== {2'b10, 8'd1, expected_sig(N1, 1'b0)}) begin
         mismatched++;
         $display("FAIL n1_result: got pass=%b fail=%b count=%0d sig=%h want 1 0 1 %h",
                  pass_1, fail_1, pattern_count_1, sig_captured_1, expected_sig(N1, 1'b0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      test_reset();
      test_golden();
      test_fault();
      test_back_to_back();
      test_abort();
      test_random_runs();
      test_async_reset();
      test_single_pattern();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
